// File: rtl/fft_mag_pkg.sv
// Shared widths and the per-stage pipeline record for the FFT magnitude square root.
// The record is sized from FFT_W/TAG_W; retarget those to change the datapath width.
package fft_mag_pkg;

  localparam int FFT_W = 16;
  localparam int TAG_W = 10;

  function automatic int magsq_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int mag_w(input int w);
    return w + 1;
  endfunction

  localparam int OW   = mag_w(FFT_W);
  localparam int RW   = 2 * OW;
  localparam int REMW = OW + 2;

  typedef struct packed {
    logic [REMW-1:0]  rem;
    logic [OW-1:0]    root;
    logic [RW-1:0]    rad;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } stage_t;

endpackage

// File: rtl/fft_sqrt_stage.sv
// One digit-by-digit square-root step: bring in two radicand bits, trial-subtract,
// decide root bit OW-1-K, and register the whole record.
module fft_sqrt_stage
  import fft_mag_pkg::*;
#(
  parameter int K = 0
) (
  input  logic   clk,
  input  logic   reset,
  input  stage_t d,
  output stage_t q
);

  logic [REMW+1:0] sh;
  logic [REMW+1:0] trial;
  logic            ge;
  stage_t          nxt;

  always_comb begin
    sh    = {d.rem, d.rad[RW-1 -: 2]};
    // Root bits are kept in their final positions; shift down to the K bits decided so far.
    trial = (REMW + 2)'({d.root >> (OW - K), 2'b01});
    ge    = sh >= trial;
    nxt   = d;
    nxt.rem = ge ? REMW'(sh - trial) : REMW'(sh);
    nxt.root[OW-1-K] = ge;
    nxt.rad = d.rad << 2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/fft_mag_sqrt.sv
// Pipelined integer square root of the squared FFT magnitude, bin tag carried alongside.
// Define FFT_MAG_SQRT_ROUND_EN for a round-to-nearest output stage (one extra cycle).
module fft_mag_sqrt
  import fft_mag_pkg::*;
#(
  parameter int W  = FFT_W,
  parameter int TW = TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [magsq_w(W)-1:0] in_mag_sq,
  input  logic [TW-1:0]         in_tag,
  output logic                  out_valid,
  output logic [mag_w(W)-1:0]   out_mag,
  output logic [TW-1:0]         out_tag
);

  stage_t pipe [0:OW];
  stage_t last;

  assign pipe[0] = '{rem: '0, root: '0, rad: RW'(in_mag_sq), tag: in_tag, valid: in_valid};

  for (genvar k = 0; k < OW; k++) begin : g_stage
    fft_sqrt_stage #(.K(k)) u_stage (
      .clk  (clk),
      .reset(reset),
      .d    (pipe[k]),
      .q    (pipe[k+1])
    );
  end

  assign last = pipe[OW];

`ifdef FFT_MAG_SQRT_ROUND_EN
  logic [OW:0] up;
  assign up = {1'b0, last.root} + 1'b1;

  // x - r^2 > r is exactly x > (r + 0.5)^2 for integers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= last.valid;
      out_tag   <= last.tag;
      if (last.rem > REMW'(last.root))
        out_mag <= up[OW] ? '1 : up[OW-1:0];
      else
        out_mag <= last.root;
    end
  end
`else
  assign out_valid = last.valid;
  assign out_mag   = last.root;
  assign out_tag   = last.tag;
`endif

endmodule
